fft_mux_tree: RTL and testbench

Parametrised, pipelined N-to-1 selection tree for the FFT core's data-reordering path. It supersedes the fixed-size 8/16/256/2048 selectors with a single block. The selector is split into radix-2^RADIX_LOG2 stages, each registered. A valid flag, the select value and an out-of-range error flag travel with the data. A clock enable stalls the whole pipeline.

---
 rtl/fft_mux_tree_pkg.sv | 32 +++
 rtl/fft_mux_tree_if.sv | 29 ++
 rtl/fft_mux_tree_stage.sv | 28 ++
 rtl/fft_mux_tree.sv | 94 +++++++++
 tb/tb_fft_mux_tree.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_mux_tree_pkg.sv
// Shared sizing helpers and the per-stage descriptor for the FFT reorder mux tree.
package fft_mux_pkg;

   // Where one stage of the tree sits in the select word and how many groups it drives.
   typedef struct packed {
      int lsb;      // first sel bit consumed by this stage
      int width;    // sel bits consumed (stage fan-in = 2**width)
      int groups;   // registered groups this stage produces
   } stage_desc_t;

   function automatic int sel_width(input int num_inputs);
      return (num_inputs <= 2) ? 1 : $clog2(num_inputs);
   endfunction

   function automatic int num_stages(input int sel_w, input int radix_log2);
      return (sel_w + radix_log2 - 1) / radix_log2;
   endfunction

   // Every stage takes a full radix slice except the last, which takes what is left.
   function automatic int stage_width(input int k, input int sel_w, input int radix_log2);
      return (k == num_stages(sel_w, radix_log2) - 1) ? (sel_w - k * radix_log2) : radix_log2;
   endfunction

   function automatic stage_desc_t stage_desc(input int k, input int sel_w, input int radix_log2);
      stage_desc_t d;
      d.lsb    = k * radix_log2;
      d.width  = stage_width(k, sel_w, radix_log2);
      d.groups = 1 << (sel_w - d.lsb - d.width);
      return d;
   endfunction

endpackage

// File: rtl/fft_mux_tree_if.sv
// Selection request / result bundle for fft_mux_tree.
interface fft_mux_tree_if
   import fft_mux_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_INPUTS = 2048,
   parameter int SEL_W      = sel_width(NUM_INPUTS)
) ();

   logic                  ce;
   logic                  in_valid;
   logic [SEL_W-1:0]      sel;
   logic [DATA_WIDTH-1:0] data_i [NUM_INPUTS];
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] data_o;
   logic [SEL_W-1:0]      out_sel;
   logic                  out_err;

   modport master (
      output ce, in_valid, sel, data_i,
      input  out_valid, data_o, out_sel, out_err
   );

   modport slave (
      input  ce, in_valid, sel, data_i,
      output out_valid, data_o, out_sel, out_err
   );

endinterface

// File: rtl/fft_mux_tree_stage.sv
// One registered radix-2**W reduction level: each output group picks one of its
// 2**W consecutive input groups using this stage's slice of the select word.
module fft_mux_tree_stage #(
   parameter int DATA_WIDTH = 8,
   parameter int GROUPS_IN  = 16,
   parameter int W          = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic [W-1:0]          idx,
   input  logic [DATA_WIDTH-1:0] d_in  [GROUPS_IN],
   output logic [DATA_WIDTH-1:0] d_out [GROUPS_IN >> W]
);

   localparam int FAN_IN     = 1 << W;
   localparam int GROUPS_OUT = GROUPS_IN >> W;

   // Per-group pick; runs every enabled cycle regardless of valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int g = 0; g < GROUPS_OUT; g++) d_out[g] <= '0;
      end else if (ce) begin
         for (int g = 0; g < GROUPS_OUT; g++) d_out[g] <= d_in[g * FAN_IN + int'(idx)];
      end
   end

endmodule

// File: rtl/fft_mux_tree.sv
// Pipelined N:1 selector for the FFT data-reorder path. Lanes are zero-padded to a
// power of two and reduced LSB slice first, one registered stage per radix slice.
// sel/valid/err ride a delay line so every stage indexes with the sel of its own item.
module fft_mux_tree
   import fft_mux_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_INPUTS = 2048,
   parameter int RADIX_LOG2 = 4
) (
   input logic          clk,
   input logic          rst,
   fft_mux_tree_if.slave bus
);

   localparam int SEL_W      = sel_width(NUM_INPUTS);
   localparam int NUM_STAGES = num_stages(SEL_W, RADIX_LOG2);
   localparam int LANES      = 1 << SEL_W;
   localparam logic [SEL_W:0] LIMIT = (SEL_W + 1)'(NUM_INPUTS);

   logic [DATA_WIDTH-1:0] lanes [LANES];
   logic [SEL_W-1:0]      sel_pipe [NUM_STAGES];
   logic [NUM_STAGES-1:0] valid_pipe;
   logic [NUM_STAGES-1:0] err_pipe;
   logic [DATA_WIDTH-1:0] final_q;

   for (genvar i = 0; i < LANES; i++) begin : g_pad
      if (i < NUM_INPUTS) begin : g_lane
         assign lanes[i] = bus.data_i[i];
      end else begin : g_zero
         assign lanes[i] = '0;
      end
   end

   // Side-band delay line: one entry per stage, entry k travels with stage k's data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_STAGES; k++) sel_pipe[k] <= '0;
         valid_pipe <= '0;
         err_pipe   <= '0;
      end else if (bus.ce) begin
         sel_pipe[0]   <= bus.sel;
         valid_pipe[0] <= bus.in_valid;
         err_pipe[0]   <= bus.in_valid && ({1'b0, bus.sel} >= LIMIT);
         for (int k = 1; k < NUM_STAGES; k++) begin
            sel_pipe[k]   <= sel_pipe[k-1];
            valid_pipe[k] <= valid_pipe[k-1];
            err_pipe[k]   <= err_pipe[k-1];
         end
      end
   end

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      localparam stage_desc_t D = stage_desc(k, SEL_W, RADIX_LOG2);
      localparam int LSB   = D.lsb;
      localparam int W     = D.width;
      localparam int G_OUT = D.groups;
      localparam int G_IN  = G_OUT << W;

      logic [W-1:0]          idx;
      logic [DATA_WIDTH-1:0] din [G_IN];
      logic [DATA_WIDTH-1:0] q   [G_OUT];

      // Stage 0 samples the live request; later stages use the sel captured with their item.
      if (k == 0) begin : g_src
         assign idx = bus.sel[LSB +: W];
         assign din = lanes;
      end else begin : g_src
         assign idx = sel_pipe[k-1][LSB +: W];
         assign din = g_stage[k-1].q;
      end

      fft_mux_tree_stage #(
         .DATA_WIDTH (DATA_WIDTH),
         .GROUPS_IN  (G_IN),
         .W          (W)
      ) u_stage (
         .clk   (clk),
         .rst   (rst),
         .ce    (bus.ce),
         .idx   (idx),
         .d_in  (din),
         .d_out (q)
      );
   end

   assign final_q       = g_stage[NUM_STAGES-1].q[0];
   // Out-of-range selections always read as zero, independent of the padding value.
   assign bus.data_o    = err_pipe[NUM_STAGES-1] ? '0 : final_q;
   assign bus.out_valid = valid_pipe[NUM_STAGES-1];
   assign bus.out_sel   = sel_pipe[NUM_STAGES-1];
   assign bus.out_err   = err_pipe[NUM_STAGES-1];

endmodule

// File: tb/tb_fft_mux_tree.sv
// Bench for fft_mux_tree: three configurations (2048/r4, 100/r3, 2/r4) driven side by
// side, directed cases plus a random run against a latency-queue reference model.
module tb_fft_mux_tree;

   typedef struct {
      logic        v;
      logic        e;
      logic [10:0] s;
      logic [7:0]  d;
   } exp_t;

   // Stage counts and padding limits worked out from the tree rules by hand.
   localparam int NS_A = 3;   // 11 sel bits: 4,4,3
   localparam int NS_B = 3;   // 7 sel bits: 3,3,1
   localparam int NS_C = 1;   // 1 sel bit

   logic clk = 1'b0;
   logic rst;
   int   n_chk;
   int   n_fail;

   exp_t q_a[$], q_b[$], q_c[$];
   exp_t last_a, last_b, last_c;

   always #5 clk = ~clk;

   fft_mux_tree_if #(.DATA_WIDTH(8), .NUM_INPUTS(2048)) ifc_a ();
   fft_mux_tree_if #(.DATA_WIDTH(8), .NUM_INPUTS(100))  ifc_b ();
   fft_mux_tree_if #(.DATA_WIDTH(8), .NUM_INPUTS(2))    ifc_c ();

   fft_mux_tree #(.DATA_WIDTH(8), .NUM_INPUTS(2048), .RADIX_LOG2(4)) dut_a (
      .clk(clk), .rst(rst), .bus(ifc_a.slave));
   fft_mux_tree #(.DATA_WIDTH(8), .NUM_INPUTS(100), .RADIX_LOG2(3)) dut_b (
      .clk(clk), .rst(rst), .bus(ifc_b.slave));
   fft_mux_tree #(.DATA_WIDTH(8), .NUM_INPUTS(2), .RADIX_LOG2(4)) dut_c (
      .clk(clk), .rst(rst), .bus(ifc_c.slave));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t zero_item();
      exp_t x;
      x.v = 1'b0; x.e = 1'b0; x.s = '0; x.d = '0;
      return x;
   endfunction

   // What the selection of the current request should produce, from the lane rules.
   function automatic exp_t item_a();
      exp_t x;
      x.v = ifc_a.in_valid;
      x.s = 11'(ifc_a.sel);
      x.e = 1'b0;
      x.d = ifc_a.data_i[ifc_a.sel];
      return x;
   endfunction

   function automatic exp_t item_b();
      exp_t x;
      x.v = ifc_b.in_valid;
      x.s = 11'(ifc_b.sel);
      x.e = ifc_b.in_valid && (int'(ifc_b.sel) >= 100);
      x.d = 8'h00;
      if (int'(ifc_b.sel) < 100) x.d = ifc_b.data_i[ifc_b.sel];
      return x;
   endfunction

   function automatic exp_t item_c();
      exp_t x;
      x.v = ifc_c.in_valid;
      x.s = 11'(ifc_c.sel);
      x.e = 1'b0;
      x.d = ifc_c.data_i[ifc_c.sel];
      return x;
   endfunction

   task automatic cmp(input string tag, input exp_t x, input logic v, input logic e,
                      input logic [10:0] s, input logic [7:0] d);
      chk({tag, ".valid"}, 32'(v), 32'(x.v));
      chk({tag, ".err"},   32'(e), 32'(x.e));
      if (x.v) begin
         chk({tag, ".sel"},  32'(s), 32'(x.s));
         chk({tag, ".data"}, 32'(d), 32'(x.d));
      end
   endtask

   task automatic rst_chk(input string tag, input logic v, input logic e,
                          input logic [10:0] s, input logic [7:0] d);
      chk({tag, ".valid"}, 32'(v), 0);
      chk({tag, ".err"},   32'(e), 0);
      chk({tag, ".sel"},   32'(s), 0);
      chk({tag, ".data"},  32'(d), 0);
   endtask

   // After reset nothing is in flight: an item needs NS enabled edges to surface.
   task automatic flush();
      q_a.delete(); q_b.delete(); q_c.delete();
      repeat (NS_A - 1) q_a.push_back(zero_item());
      repeat (NS_B - 1) q_b.push_back(zero_item());
      repeat (NS_C - 1) q_c.push_back(zero_item());
      last_a = zero_item(); last_b = zero_item(); last_c = zero_item();
   endtask

   task automatic rst_chk_all(input string tag);
      rst_chk({tag, ".a"}, ifc_a.out_valid, ifc_a.out_err, 11'(ifc_a.out_sel), ifc_a.data_o);
      rst_chk({tag, ".b"}, ifc_b.out_valid, ifc_b.out_err, 11'(ifc_b.out_sel), ifc_b.data_o);
      rst_chk({tag, ".c"}, ifc_c.out_valid, ifc_c.out_err, 11'(ifc_c.out_sel), ifc_c.data_o);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      rst_chk_all(tag);
      @(posedge clk); #1;
      rst_chk_all({tag, ".held"});
      rst = 1'b0;
      flush();
   endtask

   // One clock: capture expectations for the enabled instances, then check all three.
   task automatic step();
      exp_t xa, xb, xc;
      logic ea, eb, ec;
      xa = item_a(); xb = item_b(); xc = item_c();
      ea = ifc_a.ce; eb = ifc_b.ce; ec = ifc_c.ce;
      @(posedge clk); #1;
      if (ea) begin q_a.push_back(xa); last_a = q_a.pop_front(); end
      if (eb) begin q_b.push_back(xb); last_b = q_b.pop_front(); end
      if (ec) begin q_c.push_back(xc); last_c = q_c.pop_front(); end
      cmp("a", last_a, ifc_a.out_valid, ifc_a.out_err, 11'(ifc_a.out_sel), ifc_a.data_o);
      cmp("b", last_b, ifc_b.out_valid, ifc_b.out_err, 11'(ifc_b.out_sel), ifc_b.data_o);
      cmp("c", last_c, ifc_c.out_valid, ifc_c.out_err, 11'(ifc_c.out_sel), ifc_c.data_o);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] sel_tab [6];
      logic [7:0]  dat_tab [6];
      int          first_seen;

      sel_tab = '{11'd0, 11'd1, 11'd15, 11'd16, 11'd1023, 11'd2047};
      dat_tab = '{8'h5A, 8'h5B, 8'h55, 8'h4A, 8'hA5, 8'hA5};
      n_chk = 0; n_fail = 0;

      ifc_a.ce = 1'b0; ifc_a.in_valid = 1'b0; ifc_a.sel = '0;
      ifc_b.ce = 1'b0; ifc_b.in_valid = 1'b0; ifc_b.sel = '0;
      ifc_c.ce = 1'b0; ifc_c.in_valid = 1'b0; ifc_c.sel = '0;
      for (int k = 0; k < 2048; k++) ifc_a.data_i[k] = 8'(k) ^ 8'h5A;
      for (int k = 0; k < 100; k++)  ifc_b.data_i[k] = 8'(k * 3 + 1);
      ifc_c.data_i[0] = 8'hC3;
      ifc_c.data_i[1] = 8'h3C;

      do_reset("por");

      // Back-to-back selections on the default tree, 3-edge latency.
      ifc_a.ce = 1'b1;
      for (int i = 0; i < 9; i++) begin
         ifc_a.in_valid = (i < 6);
         ifc_a.sel      = (i < 6) ? sel_tab[i] : 11'd0;
         step();
         if (i >= 2 && i < 8) begin
            chk("dir_a.data",  32'(ifc_a.data_o),    32'(dat_tab[i-2]));
            chk("dir_a.sel",   32'(ifc_a.out_sel),   32'(sel_tab[i-2]));
            chk("dir_a.valid", 32'(ifc_a.out_valid), 1);
         end
      end
      ifc_a.ce = 1'b0; ifc_a.in_valid = 1'b0;

      // Last in-range lane and first out-of-range lane on the 100-lane tree.
      ifc_b.ce = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ifc_b.in_valid = (i < 2);
         ifc_b.sel      = (i == 0) ? 7'd99 : 7'd100;
         step();
         if (i == 2) begin
            chk("dir_b99.data", 32'(ifc_b.data_o),  32'(8'h2A));
            chk("dir_b99.err",  32'(ifc_b.out_err), 0);
         end
         if (i == 3) begin
            chk("dir_b100.data", 32'(ifc_b.data_o),  0);
            chk("dir_b100.err",  32'(ifc_b.out_err), 1);
            chk("dir_b100.sel",  32'(ifc_b.out_sel), 100);
         end
      end
      ifc_b.ce = 1'b0; ifc_b.in_valid = 1'b0;

      // Single-stage tree: alternating lanes with one-edge latency.
      ifc_c.ce = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ifc_c.in_valid = 1'b1;
         ifc_c.sel      = 1'(i % 2);
         step();
         chk("dir_c.valid", 32'(ifc_c.out_valid), 1);
         chk("dir_c.data",  32'(ifc_c.data_o), (i % 2 == 1) ? 32'h3C : 32'hC3);
      end
      ifc_c.ce = 1'b0; ifc_c.in_valid = 1'b0;

      // Stall: one enabled edge, four held edges, then enabled again.
      do_reset("stall_rst");
      first_seen = -1;
      ifc_a.sel = 11'd5;
      for (int i = 1; i <= 12; i++) begin
         ifc_a.ce       = !(i >= 2 && i <= 5);
         ifc_a.in_valid = (i == 1);
         step();
         if (first_seen < 0 && ifc_a.out_valid) begin
            first_seen = i;
            chk("stall.data", 32'(ifc_a.data_o), 32'(8'h5F));
         end
      end
      chk("stall.first_valid_edge", 32'(first_seen), 7);
      ifc_a.ce = 1'b0; ifc_a.in_valid = 1'b0;

      // Reset between edges with items in flight.
      ifc_a.ce = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ifc_a.in_valid = 1'b1;
         ifc_a.sel      = 11'(100 + i);
         step();
      end
      chk("mid.pre_valid", 32'(ifc_a.out_valid), 1);
      #3;
      do_reset("mid");
      ifc_a.in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("mid.post_valid", 32'(ifc_a.out_valid), 0);
      end

      // Random regression on all three trees at once.
      for (int cyc = 0; cyc < 10000; cyc++) begin
         ifc_a.ce       = ($urandom_range(0, 3) != 0);
         ifc_a.in_valid = $urandom_range(0, 1);
         ifc_a.sel      = 11'($urandom_range(0, 2047));
         for (int j = 0; j < 16; j++) ifc_a.data_i[$urandom_range(0, 2047)] = 8'($urandom);
         ifc_b.ce       = ($urandom_range(0, 3) != 0);
         ifc_b.in_valid = $urandom_range(0, 1);
         ifc_b.sel      = 7'($urandom_range(0, 127));
         for (int j = 0; j < 100; j++) ifc_b.data_i[j] = 8'($urandom);
         ifc_c.ce       = ($urandom_range(0, 3) != 0);
         ifc_c.in_valid = $urandom_range(0, 1);
         ifc_c.sel      = 1'($urandom_range(0, 1));
         ifc_c.data_i[0] = 8'($urandom);
         ifc_c.data_i[1] = 8'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
